// File: rtl/smi_mem_fuzz_test_scheduler.sv
// Splits one memory test request into aligned per-lane fuzz tester windows,
// dispatches them lane by lane, then folds the lane error counts into one result.
module smi_mem_fuzz_test_scheduler #(
    parameter int NumLanesLog2 = 1,
    parameter int AlignBytes   = 64,
    localparam int NumLanes    = 1 << NumLanesLog2
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     configValid,
    input  logic [63:0]              configMemAddrBase,
    input  logic [31:0]              configMemBlockSize,
    input  logic [31:0]              configNumTests,
    output logic                     configStop,
    output logic [NumLanes-1:0]      laneConfigValid,
    output logic [63:0]              laneConfigAddrBase,
    output logic [31:0]              laneConfigBlockSize,
    output logic [31:0]              laneConfigNumTests,
    input  logic [NumLanes-1:0]      laneConfigStop,
    input  logic [NumLanes-1:0]      laneStatusValid,
    input  logic [32*NumLanes-1:0]   laneStatusErrorCount,
    output logic [NumLanes-1:0]      laneStatusStop,
    output logic                     statusValid,
    output logic [31:0]              statusErrorCount,
    output logic [NumLanes-1:0]      statusLaneFail,
    input  logic                     statusStop,
    output logic [2:0]               debugState
);

    // Every channel: a transfer happens on the rising clk edge where valid=1
    // and stop=0; valid is held with stable data until that transfer.

    typedef enum logic [2:0] {
        ST_RESET,
        ST_IDLE,
        ST_DISPATCH,
        ST_COLLECT,
        ST_REPORT
    } state_t;

    state_t state, state_next;

    logic [63:0]         lane_addr;
    logic [31:0]         lane_size;
    logic [31:0]         num_tests;
    logic [3:0]          lane_idx;
    logic [31:0]         err_acc;
    logic [NumLanes-1:0] fail_mask;
    logic [NumLanes-1:0] done_mask;

    logic [31:0]         lane_size_in;
    logic                cfg_xfer;
    logic [NumLanes-1:0] lane_onehot;
    logic                lane_xfer;
    logic                last_lane;
    logic [NumLanes-1:0] stat_xfer;
    logic [35:0]         sum_wide;
    logic [31:0]         err_next;
    logic [NumLanes-1:0] fail_next;
    logic [NumLanes-1:0] done_next;

    // Transfer qualifiers are built from state, not from the stop outputs,
    // so the collect path has no combinational loop through the output logic.
    always_comb begin
        lane_size_in = (configMemBlockSize >> NumLanesLog2) & ~32'(AlignBytes - 1);
        cfg_xfer     = configValid && (state == ST_IDLE);
        lane_onehot  = NumLanes'(1) << lane_idx;
        lane_xfer    = (state == ST_DISPATCH) && |(lane_onehot & ~laneConfigStop);
        last_lane    = (lane_idx == 4'(NumLanes - 1));
        stat_xfer    = (state == ST_COLLECT) ? (laneStatusValid & ~done_mask) : '0;
    end

    // Up to eight 32-bit counts plus the accumulator fit in 36 bits; any
    // carry beyond bit 31 saturates the reported count.
    always_comb begin
        sum_wide  = {4'b0, err_acc};
        fail_next = fail_mask;
        for (int i = 0; i < NumLanes; i++) begin
            if (stat_xfer[i]) begin
                sum_wide = sum_wide + {4'b0, laneStatusErrorCount[32*i +: 32]};
                if (laneStatusErrorCount[32*i +: 32] != 32'd0) begin
                    fail_next[i] = 1'b1;
                end
            end
        end
        err_next  = (|sum_wide[35:32]) ? 32'hFFFF_FFFF : sum_wide[31:0];
        done_next = done_mask | stat_xfer;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        configStop      = 1'b1;
        laneConfigValid = '0;
        laneStatusStop  = '1;
        statusValid     = 1'b0;
        case (state)
            ST_RESET: begin
                state_next = ST_IDLE;
            end
            ST_IDLE: begin
                configStop = 1'b0;
                if (cfg_xfer) begin
                    if (lane_size_in == 32'd0 || configNumTests == 32'd0) begin
                        state_next = ST_REPORT;
                    end else begin
                        state_next = ST_DISPATCH;
                    end
                end
            end
            ST_DISPATCH: begin
                laneConfigValid = lane_onehot;
                if (lane_xfer && last_lane) begin
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                laneStatusStop = done_mask;
                if (&done_next) begin
                    state_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                statusValid = 1'b1;
                if (!statusStop) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_RESET;
            end
        endcase
    end

    // The lane base advances by one lane size per accepted dispatch, which
    // equals base + idx*size with natural 64-bit wrap.
    always_ff @(posedge clk) begin
        if (srst) begin
            lane_idx  <= 4'd0;
            err_acc   <= 32'd0;
            fail_mask <= '0;
            done_mask <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_xfer) begin
                        lane_addr <= configMemAddrBase;
                        lane_size <= lane_size_in;
                        num_tests <= configNumTests;
                        lane_idx  <= 4'd0;
                        err_acc   <= (lane_size_in == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
                        fail_mask <= '0;
                        done_mask <= '0;
                    end
                end
                ST_DISPATCH: begin
                    if (lane_xfer) begin
                        lane_idx  <= lane_idx + 4'd1;
                        lane_addr <= lane_addr + {32'd0, lane_size};
                    end
                end
                ST_COLLECT: begin
                    err_acc   <= err_next;
                    fail_mask <= fail_next;
                    done_mask <= done_next;
                end
                default: begin
                end
            endcase
        end
    end

    assign laneConfigAddrBase  = lane_addr;
    assign laneConfigBlockSize = lane_size;
    assign laneConfigNumTests  = num_tests;
    assign statusErrorCount    = err_acc;
    assign statusLaneFail      = fail_mask;
    assign debugState          = state;

endmodule
